maxpool_2x2: RTL and testbench

- Streaming 2x2, stride-2 max-pooling block for the U-Net encoder path; the downsampling counterpart to the transconv upsampler on the decoder path.
- Consumes one signed feature-map pixel per accepted beat in raster order and emits one pooled pixel per 2x2 window, also in raster order.
- Sits between a conv stage output and the next encoder conv stage. Feature maps are square: height equals the runtime width.

---
 rtl/maxpool_2x2.sv | 197 +++++++++++++++++++
 tb/tb_maxpool_2x2.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2.sv
// ---------------------------------------------------------------------------
// maxpool_2x2
//
// Streaming 2x2, stride-2 max-pooling stage for the U-Net encoder path.
// Input pixels arrive one per valid beat in raster order. One pooled pixel
// is produced per 2x2 window, also in raster order. The feature map is
// square: its height equals the runtime width.
//
// Row pairs are reduced in two passes:
//   - Even input rows. Each horizontal pair max(p[2c], p[2c+1]) is parked in
//     a half-width line buffer.
//   - Odd input rows. Each horizontal pair max is combined with the parked
//     value from the row above, and the result is emitted.
//
// Handshake: in_valid qualifies in_pixel. Every valid beat is accepted and
// there is no backpressure. out_valid is a one-cycle pulse, registered one
// clock after the beat that completes a window. out_row_end and frame_done
// are only ever high together with out_valid.
//
// Optional build macro:
//   MAXPOOL_RELU_EN  When defined, negative pooled results are clamped to 0
//                    (fused ReLU). Output timing is identical in both builds.
//
// Parameters:
//   IMAGE_WIDTH  maximum feature-map width; the line buffer holds
//                IMAGE_WIDTH/2 entries
//   DATA_W       signed pixel width, in and out
//   CNT_W        width of the runtime width input and of the row/col counters
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   width        runtime width (even, 2..IMAGE_WIDTH); sampled on the first
//                beat of each frame
//   in_valid     in_pixel is valid this cycle
//   in_pixel     signed input pixel
//   out_valid    one-cycle pulse; out_pixel holds a pooled result
//   out_pixel    signed pooled pixel
//   out_row_end  last pooled pixel of an output row
//   frame_done   last pooled pixel of the frame
// ---------------------------------------------------------------------------
module maxpool_2x2 #(
    parameter int IMAGE_WIDTH = 128,
    parameter int DATA_W      = 20,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         width,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_pixel,
    output logic                     out_row_end,
    output logic                     frame_done
);

    localparam int LB_DEPTH = IMAGE_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    // IDLE: waiting for the first beat of a frame.
    // EVEN: processing an even input row.
    // ODD:  processing an odd input row.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           col;
    logic [CNT_W-1:0]           row;
    logic [CNT_W-1:0]           w_reg;
    logic signed [DATA_W-1:0]   hold;
    logic signed [DATA_W-1:0]   linebuf [LB_DEPTH];

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]           w_eff;
    logic [CNT_W-1:0]           w_last;
    logic                       col_last;
    logic                       row_last;
    logic                       odd_row;
    logic [LB_AW-1:0]           lb_addr;
    logic signed [DATA_W-1:0]   lb_rd;
    logic signed [DATA_W-1:0]   pair_max;
    logic signed [DATA_W-1:0]   pool_max;
    logic signed [DATA_W-1:0]   result;
    logic                       out_fire;
    logic                       lb_we;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        // The first beat of a frame arrives while still in IDLE, so its wrap
        // decision must use the live width input instead of w_reg. Only a
        // width of 1 (illegal) could wrap on that first beat.
        w_eff    = (state == IDLE) ? width : w_reg;
        w_last   = w_eff - CNT_W'(1);
        col_last = (col == w_last);
        row_last = (row == w_last);
        // IDLE behaves as row 0, which is an even row.
        odd_row  = (state == ODD);

        // Truncating the address keeps illegal widths inside the buffer.
        // Those widths give unspecified data, but never an unknown index.
        lb_addr  = LB_AW'(col >> 1);
        lb_rd    = linebuf[lb_addr];

        pair_max = smax(hold, in_pixel);
        pool_max = smax(pair_max, lb_rd);

`ifdef MAXPOOL_RELU_EN
        // Applying ReLU after the max gives the same result as applying it
        // before, so a single clamp on the pooled value is enough.
        result   = pool_max[DATA_W-1] ? '0 : pool_max;
`else
        result   = pool_max;
`endif

        out_fire = in_valid && odd_row && col[0];
        lb_we    = in_valid && !odd_row && col[0] && !rst;
    end

    // -----------------------------------------------------------------------
    // Line buffer: one horizontal pair max per output column.
    // No reset is needed: every entry is written on an even row before the
    // following odd row reads it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_addr] <= pair_max;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM, counters and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            w_reg       <= '0;
            hold        <= '0;
            out_valid   <= 1'b0;
            out_pixel   <= '0;
            out_row_end <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            // Idle cycles clear the flags, which keeps out_valid a single-cycle
            // pulse. out_pixel keeps its last value between pulses.
            out_valid   <= out_fire;
            out_row_end <= out_fire && col_last;
            frame_done  <= out_fire && col_last && row_last;
            if (out_fire) begin
                out_pixel <= result;
            end

            if (in_valid) begin
                if (state == IDLE) begin
                    w_reg <= width;
                end

                // The left pixel of each horizontal pair waits in hold.
                if (!col[0]) begin
                    hold <= in_pixel;
                end

                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        // The frame ends on the last row even for an illegal odd
                        // width, so a bad width can never trap the counters.
                        row   <= '0;
                        state <= IDLE;
                    end else begin
                        row   <= row + CNT_W'(1);
                        state <= odd_row ? EVEN : ODD;
                    end
                end else begin
                    col <= col + CNT_W'(1);
                    if (state == IDLE) begin
                        state <= EVEN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// tb_maxpool_2x2
//
// Self-checking bench for maxpool_2x2.
//
// Each pooled output is modelled directly as the maximum over its 2x2 input
// window, taken from the raster-ordered frame in pix_q. The row_end and
// frame_done flags come from the window's position in the output grid.
// A capture process records every out_valid pulse, together with the cycle
// on which it was seen. Each test task compares what was captured against
// the expected queue it built for itself.
// ---------------------------------------------------------------------------
module tb_maxpool_2x2;

    localparam int IMAGE_WIDTH = 128;
    localparam int DATA_W      = 20;
    localparam int CNT_W       = 8;
    localparam int REC_W       = DATA_W + 2;

    logic                     clk;
    logic                     rst;
    logic [CNT_W-1:0]         width;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_pixel;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_pixel;
    logic                     out_row_end;
    logic                     frame_done;

    maxpool_2x2 #(
        .IMAGE_WIDTH(IMAGE_WIDTH),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .width      (width),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .out_row_end(out_row_end),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    // Record layout: {frame_done, out_row_end, out_pixel}
    logic [REC_W-1:0]         exp_q[$];
    logic [REC_W-1:0]         got_q[$];
    int                       got_cyc[$];
    logic signed [DATA_W-1:0] pix_q[$];
    int                       total = 0;
    int                       bad = 0;
    int                       last_beat_cyc = 0;

    // Capture outputs away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_q.push_back({frame_done, out_row_end, out_pixel});
            got_cyc.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [REC_W-1:0] model_out(input int w, input int r, input int c);
        logic signed [DATA_W-1:0] m;
        logic signed [DATA_W-1:0] v;
        m = pix_q[(2 * r) * w + 2 * c];
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = pix_q[(2 * r + dy) * w + 2 * c + dx];
                if (v > m) m = v;
            end
        end
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = '0;
`endif
        return {((r == w / 2 - 1) && (c == w / 2 - 1)), (c == w / 2 - 1), m};
    endfunction

    task automatic expect_frame(input int w);
        for (int r = 0; r < w / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                exp_q.push_back(model_out(w, r, c));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic set_ramp(input int n, input int base);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(DATA_W'(base + i));
    endtask

    function automatic logic signed [DATA_W-1:0] rand_pix();
        logic [31:0] r;
        int          pick;
        r    = $urandom;
        pick = $urandom_range(0, 9);
        if (pick == 0) return {1'b1, {(DATA_W - 1){1'b0}}};
        if (pick == 1) return {1'b0, {(DATA_W - 1){1'b1}}};
        return r[DATA_W-1:0];
    endfunction

    // Drives every pixel of pix_q with `gap` idle cycles after each beat.
    // in_valid is left high after the final beat, so a second call continues
    // on the very next cycle with no bubble.
    task automatic drive_frame(input int w, input int gap, input bit scramble);
        for (int i = 0; i < pix_q.size(); i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_pixel = pix_q[i];
            width    = (i == 0 || !scramble) ? CNT_W'(w) : CNT_W'($urandom_range(0, 255));
            last_beat_cyc = cyc;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_pixel = DATA_W'($urandom);
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for n captured outputs, then a short tail so that any
    // extra output pulses are also captured.
    task automatic drain(input int n);
        for (int k = 0; k < 40; k++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_sb();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_pixel = DATA_W'(1000);
        width    = CNT_W'(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_pixel !== '0) begin bad++; $display("FAIL reset_out_pixel got=%0d exp=0", out_pixel); end
        if (out_row_end !== 1'b0) begin bad++; $display("FAIL reset_row_end got=%b exp=0", out_row_end); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        // The beats offered during reset must have been dropped.
        pix_q.delete();
        pix_q.push_back(20'sd10);
        pix_q.push_back(-20'sd20);
        pix_q.push_back(20'sd30);
        pix_q.push_back(20'sd5);
        expect_frame(2);
        drive_frame(2, 0, 1'b0);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL after_reset_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL after_reset[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
    endtask

    task automatic test_ramp(input int w);
        clear_sb();
        set_ramp(w * w, 0);
        expect_frame(w);
        drive_frame(w, 0, 1'b0);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ramp%0d_count got=%0d exp=%0d", w, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL ramp%0d[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", w, i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
    endtask

    task automatic test_negative();
        clear_sb();
        pix_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back((i == 10) ? -20'sd1 : -20'sd100);
        expect_frame(4);
        drive_frame(4, 0, 1'b0);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL negative_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL negative[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
    endtask

    task automatic test_idle_gaps();
        clear_sb();
        pix_q.delete();
        pix_q.push_back(20'sd3);
        pix_q.push_back(-20'sd7);
        pix_q.push_back(20'sd9);
        pix_q.push_back(20'sd1);
        expect_frame(2);
        drive_frame(2, 2, 1'b1);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== 1) begin bad++; $display("FAIL gaps_count got=%0d exp=1", got_q.size()); end
        total++;
        if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL gaps_value got=%0h exp=%0h", (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]);
        end
        total++;
        if (got_cyc.size() < 1 || got_cyc[0] !== last_beat_cyc + 1) begin
            bad++;
            $display("FAIL gaps_latency got_cycle=%0d exp_cycle=%0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, last_beat_cyc + 1);
        end
    endtask

    task automatic test_rst_mid_frame();
        clear_sb();
        // Five beats of a width-4 frame: row 0 plus one pixel of row 1, so
        // no window is complete yet.
        set_ramp(5, 0);
        drive_frame(4, 0, 1'b0);
        go_idle();
        repeat (3) @(negedge clk);
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL rst_mid_early_out got=%0d exp=0", got_q.size()); end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ramp(4, 1);
        expect_frame(2);
        drive_frame(2, 0, 1'b0);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_mid[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        clear_sb();
        set_ramp(16, 0);
        expect_frame(4);
        drive_frame(4, 0, 1'b0);
        pix_q.delete();
        repeat (4) pix_q.push_back(20'sd8);
        expect_frame(2);
        drive_frame(2, 0, 1'b0);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
        dones = 0;
        foreach (got_q[i]) if (got_q[i][DATA_W+1]) dones++;
        total++;
        if (dones !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d exp=2", dones); end
    endtask

    task automatic test_random(input int w, input int max_gap);
        clear_sb();
        pix_q.delete();
        for (int i = 0; i < w * w; i++) pix_q.push_back(rand_pix());
        expect_frame(w);
        drive_frame(w, $urandom_range(0, max_gap), 1'b1);
        go_idle();
        drain(exp_q.size());
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL random_w%0d_count got=%0d exp=%0d", w, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [REC_W-1:0] a;
            a = (i < got_q.size()) ? got_q[i] : 'x;
            total++;
            if (a !== exp_q[i]) begin
                bad++;
                $display("FAIL random_w%0d[%0d] got pix=%0d re=%b done=%b exp pix=%0d re=%b done=%b", w, i,
                         $signed(a[DATA_W-1:0]), a[DATA_W], a[DATA_W+1],
                         $signed(exp_q[i][DATA_W-1:0]), exp_q[i][DATA_W], exp_q[i][DATA_W+1]);
            end
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        width    = CNT_W'(4);
        repeat (2) @(posedge clk);
        test_reset();
        test_ramp(4);
        test_negative();
        test_idle_gaps();
        test_rst_mid_frame();
        test_back_to_back();
        test_ramp(8);
        for (int f = 0; f < 6; f++) test_random(2 * $urandom_range(1, 8), 1);
        test_random(2, 0);
        test_random(IMAGE_WIDTH, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
